// File: rtl/pacman_pkg.sv
// Shared types for the ghost frightened-mode scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pacman_pkg;

  // Palette ROM select driven to sprite draw logic
  typedef enum logic [1:0] {
    PAL_NORMAL = 2'd0,
    PAL_BLUE   = 2'd1,
    PAL_WHITE  = 2'd2,
    PAL_EYES   = 2'd3
  } pal_sel_t;

  // Global fright timer state
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FRIGHT = 2'd1,
    FS_FLASH  = 2'd2
  } fright_state_t;

  // Colour currently shown while flashing
  typedef enum logic {
    PH_BLUE  = 1'b0,
    PH_WHITE = 1'b1
  } flash_phase_t;

endpackage

// File: rtl/ghost_fright_slice.sv
// Per-ghost fright/eyes flags and registered palette select for one ghost.
// Latency: 1 cycle from any input pulse to pal_sel change.
// Backpressure: none; pulses are consumed in the cycle they arrive.
module ghost_fright_slice
  import pacman_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pellet,     // power pellet this cycle
  input  logic     timeout,    // global fright timer expired this cycle
  input  logic     white_nxt,  // timer will be flashing white next cycle
  input  logic     eaten,      // Pac-Man collided with this ghost
  input  logic     home,       // eyes reached the ghost house
  output logic     fright,     // current frightened flag
  output logic     eat_hit,    // collision counts as an eat this cycle
  output pal_sel_t pal_sel
);

  logic     eyes;
  logic     fright_nxt;
  logic     eyes_nxt;
  pal_sel_t pal_nxt;

  // An eat only counts against a ghost that is frightened before this edge
  assign eat_hit = eaten & fright;

  // Next flag values; an eat beats pellet, timeout and home for this ghost
  always_comb begin
    fright_nxt = fright;
    eyes_nxt   = eyes;
    if (eat_hit) begin
      fright_nxt = 1'b0;
      eyes_nxt   = 1'b1;
    end else begin
      if (pellet && !eyes) begin
        fright_nxt = 1'b1;
      end else if (timeout) begin
        fright_nxt = 1'b0;
      end
      if (home) begin
        eyes_nxt = 1'b0;
      end
    end
    if (eyes_nxt) begin
      pal_nxt = PAL_EYES;
    end else if (fright_nxt) begin
      pal_nxt = white_nxt ? PAL_WHITE : PAL_BLUE;
    end else begin
      pal_nxt = PAL_NORMAL;
    end
  end

  // Flag and palette registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fright  <= 1'b0;
      eyes    <= 1'b0;
      pal_sel <= PAL_NORMAL;
    end else begin
      fright  <= fright_nxt;
      eyes    <= eyes_nxt;
      pal_sel <= pal_nxt;
    end
  end

endmodule

// File: rtl/ghost_fright_sched.sv
// Frightened-mode timer, flash phase and eat-combo counter driving per-ghost palette selects.
// Latency: 1 cycle from input pulse to any output change; all outputs registered.
// Backpressure: none; every pulse is acted on in the cycle it arrives.
module ghost_fright_sched
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int FRIGHT_FRAMES = 360,
  parameter int FLASH_FRAMES  = 120,
  parameter int FLASH_HALF    = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    pellet_eaten,
  input  logic [NUM_GHOSTS-1:0]   ghost_eaten,
  input  logic [NUM_GHOSTS-1:0]   ghost_home,
  output logic [2*NUM_GHOSTS-1:0] pal_sel,
  output logic                    fright_active,
  output logic                    eat_valid,
  output logic [1:0]              eat_count
);

  localparam int FW = $clog2(FRIGHT_FRAMES + 1);
  // Keep the half counter at least one bit wide when FLASH_HALF is 1
  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  fright_state_t   state, state_nxt;
  flash_phase_t    phase, phase_nxt;
  logic [FW-1:0]   frame_cnt, frame_nxt, frame_dec;
  logic [HW-1:0]   half_cnt, half_nxt;
  logic            timeout;
  logic            white_nxt;
  logic [1:0]      eat_count_nxt;
  logic [NUM_GHOSTS-1:0] fright_vec;
  logic [NUM_GHOSTS-1:0] eat_hit;
  pal_sel_t        pal_vec [NUM_GHOSTS];

  assign frame_dec = frame_cnt - FW'(1);

  // Timer/phase next state; pellet restarts the timer and masks a same-cycle tick
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    frame_nxt = frame_cnt;
    half_nxt  = half_cnt;
    timeout   = 1'b0;
    if (pellet_eaten) begin
      state_nxt = FS_FRIGHT;
      frame_nxt = FW'(FRIGHT_FRAMES);
      phase_nxt = PH_BLUE;
      half_nxt  = HW'(FLASH_HALF - 1);
    end else if (frame_tick) begin
      case (state)
        FS_FRIGHT: begin
          frame_nxt = frame_dec;
          if (frame_dec == FW'(FLASH_FRAMES)) begin
            state_nxt = FS_FLASH;
            phase_nxt = PH_BLUE;
            half_nxt  = HW'(FLASH_HALF - 1);
          end
        end
        FS_FLASH: begin
          frame_nxt = frame_dec;
          if (half_cnt == '0) begin
            phase_nxt = (phase == PH_BLUE) ? PH_WHITE : PH_BLUE;
            half_nxt  = HW'(FLASH_HALF - 1);
          end else begin
            half_nxt = half_cnt - HW'(1);
          end
          if (frame_dec == '0) begin
            state_nxt = FS_IDLE;
            phase_nxt = PH_BLUE;
            timeout   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign white_nxt = (state_nxt == FS_FLASH) && (phase_nxt == PH_WHITE);

  // Combo counter: add this cycle's valid eats, saturate at 3, pellet clears
  always_comb begin
    int hits;
    int sum;
    hits = 0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      hits = hits + int'(eat_hit[i]);
    end
    sum = int'(eat_count) + hits;
    if (pellet_eaten) begin
      eat_count_nxt = 2'd0;
    end else if (sum > 3) begin
      eat_count_nxt = 2'd3;
    end else begin
      eat_count_nxt = 2'(sum);
    end
  end

  // Global timer, phase and scoring registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FS_IDLE;
      phase         <= PH_BLUE;
      frame_cnt     <= '0;
      half_cnt      <= '0;
      fright_active <= 1'b0;
      eat_valid     <= 1'b0;
      eat_count     <= 2'd0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      frame_cnt     <= frame_nxt;
      half_cnt      <= half_nxt;
      fright_active <= (state_nxt != FS_IDLE);
      eat_valid     <= |eat_hit;
      eat_count     <= eat_count_nxt;
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_slice
    ghost_fright_slice u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .pellet    (pellet_eaten),
      .timeout   (timeout),
      .white_nxt (white_nxt),
      .eaten     (ghost_eaten[g]),
      .home      (ghost_home[g]),
      .fright    (fright_vec[g]),
      .eat_hit   (eat_hit[g]),
      .pal_sel   (pal_vec[g])
    );
    assign pal_sel[2*g +: 2] = pal_vec[g];
  end

endmodule

// File: tb/tb_ghost_fright_sched.sv
module tb_ghost_fright_sched;

  localparam int NG = 4;
  localparam int FF = 10;
  localparam int FL = 4;
  localparam int FH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          pellet_eaten = 1'b0;
  logic [NG-1:0] ghost_eaten = '0;
  logic [NG-1:0] ghost_home = '0;
  logic [2*NG-1:0] pal_sel;
  logic          fright_active;
  logic          eat_valid;
  logic [1:0]    eat_count;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: remaining frames plus per-ghost flags
  bit m_act;
  int m_rem;
  bit m_fr [NG];
  bit m_ey [NG];
  int m_cnt;
  bit m_ev;

  ghost_fright_sched #(
    .NUM_GHOSTS(NG), .FRIGHT_FRAMES(FF), .FLASH_FRAMES(FL), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pellet_eaten(pellet_eaten),
    .ghost_eaten(ghost_eaten), .ghost_home(ghost_home), .pal_sel(pal_sel),
    .fright_active(fright_active), .eat_valid(eat_valid), .eat_count(eat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_rem = 0; m_cnt = 0; m_ev = 0;
    for (int i = 0; i < NG; i++) begin
      m_fr[i] = 0; m_ey[i] = 0;
    end
  endtask

  // Flashing starts when FL frames remain; colour flips every FH frames after that
  function automatic int exp_pal(input int i);
    bit white;
    white = m_act && (m_rem <= FL) && ((((FL - m_rem) / FH) % 2) == 1);
    if (m_ey[i]) return 3;
    if (m_fr[i]) return white ? 2 : 1;
    return 0;
  endfunction

  task automatic model_step(input bit p, input bit t, input logic [NG-1:0] e,
                            input logic [NG-1:0] h);
    bit valid [NG];
    int hits;
    bit expired;
    hits = 0;
    expired = 0;
    for (int i = 0; i < NG; i++) begin
      valid[i] = e[i] && m_fr[i];
      if (valid[i]) hits++;
    end
    if (p) begin
      m_act = 1; m_rem = FF;
    end else if (m_act && t) begin
      m_rem--;
      if (m_rem == 0) begin
        m_act = 0; expired = 1;
      end
    end
    for (int i = 0; i < NG; i++) begin
      if (valid[i]) begin
        m_fr[i] = 0; m_ey[i] = 1;
      end else begin
        if (p && !m_ey[i]) m_fr[i] = 1;
        else if (expired) m_fr[i] = 0;
        if (h[i]) m_ey[i] = 0;
      end
    end
    m_cnt = p ? 0 : ((m_cnt + hits > 3) ? 3 : m_cnt + hits);
    m_ev = (hits > 0);
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < NG; i++) begin
      check($sformatf("%s pal_sel[%0d]", ctx, i), int'(pal_sel[2*i +: 2]), exp_pal(i));
    end
    check({ctx, " fright_active"}, int'(fright_active), int'(m_act));
    check({ctx, " eat_valid"}, int'(eat_valid), int'(m_ev));
    check({ctx, " eat_count"}, int'(eat_count), m_cnt);
  endtask

  task automatic step(input string ctx, input bit p, input bit t,
                      input logic [NG-1:0] e, input logic [NG-1:0] h);
    pellet_eaten = p; frame_tick = t; ghost_eaten = e; ghost_home = h;
    @(posedge clk);
    model_step(p, t, e, h);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 0, 0, '0, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic async_reset(input string ctx);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    pellet_eaten = 0; frame_tick = 0; ghost_eaten = '0; ghost_home = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Inputs toggling under reset must not leak through
    for (int k = 0; k < 3; k++) begin
      pellet_eaten = 1'b1; frame_tick = 1'b1; ghost_eaten = '1; ghost_home = '1;
      @(posedge clk);
      #1;
      check_all("in_reset");
    end
    pellet_eaten = 0; frame_tick = 0; ghost_eaten = '0; ghost_home = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Full fright timeout with flashing
    step("pellet", 1, 0, '0, '0);
    for (int k = 0; k < FF; k++) begin
      step($sformatf("tick%0d", k + 1), 0, 1, '0, '0);
      idle(1);
    end

    // Eat all four ghosts, combo saturates, one ghost goes home
    step("pellet2", 1, 0, '0, '0);
    for (int g = 0; g < NG; g++) step($sformatf("eat%0d", g), 0, 0, 4'(1 << g), '0);
    step("home0", 0, 0, '0, 4'b0001);
    step("eat_eyes2", 0, 0, 4'b0100, '0);
    for (int k = 0; k < FF; k++) step("drain", 0, 1, '0, '0);
    step("home_rest", 0, 0, '0, 4'b1110);
    step("eat_idle2", 0, 0, 4'b0100, '0);

    // Pellet during flash while ghost1 is eyes
    step("pellet3", 1, 0, '0, '0);
    step("eat1", 0, 0, 4'b0010, '0);
    for (int k = 0; k < FF - 2; k++) step("to_flash", 0, 1, '0, '0);
    step("repellet", 1, 0, '0, '0);
    step("after_repellet", 0, 1, '0, '0);

    // Pellet, tick and valid eat together
    step("combo", 1, 1, 4'b0001, '0);
    for (int k = 0; k < FF - 3; k++) step("to_flash2", 0, 1, '0, '0);
    async_reset("async_rst");
    idle(2);

    // Randomised traffic
    for (int k = 0; k < 4000; k++) begin
      logic [NG-1:0] e, h;
      for (int i = 0; i < NG; i++) begin
        e[i] = ($urandom % 6) == 0;
        h[i] = ($urandom % 5) == 0;
      end
      step("rand", ($urandom % 30) == 0, ($urandom % 3) != 0, e, h);
      if (k == 2500) async_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
